// File: rtl/sd_crc_lanes_if.sv
// sd_crc_lanes_if
//   Signal bundle for the multi-lane SD CRC generator/checker.
//   master: the controller side that drives the strobes and serial data.
//   slave : the CRC block.
//   Inputs : clear, bit_en, data_in[LANES], crc_start, mode
//   Outputs: crc_out[LANES], crc_phase, done, crc_err[LANES],
//            crc[LANES*WIDTH], state_dbg (FSM state)
//
// Handshake: there is no backpressure. bit_en is a one-cycle qualifier.
// On every clk edge where bit_en is high, data_in carries exactly one bit
// per lane and the block always consumes it. crc_start is a one-cycle
// pulse with the same always-accept semantics, but it only counts in the
// accumulate state.
interface sd_crc_lanes_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
);
  logic                   clear;
  logic                   bit_en;
  logic [LANES-1:0]       data_in;
  logic                   crc_start;
  logic                   mode;
  logic [LANES-1:0]       crc_out;
  logic                   crc_phase;
  logic                   done;
  logic [LANES-1:0]       crc_err;
  logic [LANES*WIDTH-1:0] crc;
  logic [1:0]             state_dbg;

  modport master (
    output clear, bit_en, data_in, crc_start, mode,
    input  crc_out, crc_phase, done, crc_err, crc, state_dbg
  );

  modport slave (
    input  clear, bit_en, data_in, crc_start, mode,
    output crc_out, crc_phase, done, crc_err, crc, state_dbg
  );
endinterface

// File: rtl/sd_crc_lanes.sv
// sd_crc_lanes
//   Runs LANES independent MSB-first CRC shift registers, one bit per lane
//   per bit_en. After the payload, crc_start enters the CRC phase. The block
//   then either shifts each CRC out serially (mode 0, generate) or compares
//   the next WIDTH received bits against it (mode 1, check). In check mode
//   it sets sticky per-lane error flags.
//   Ports:
//     clk     - clock, all logic on posedge
//     reset_n - asynchronous active-low reset
//     bus     - sd_crc_lanes_if slave (see interface for signal list)
//   state_dbg encoding: 0 = ACCUM, 1 = CRC, 2 = DONE.
module sd_crc_lanes #(
  parameter int               LANES = 4,
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'('h1021)
) (
  input  logic               clk,
  input  logic               reset_n,
  sd_crc_lanes_if.slave      bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CRC   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [LANES-1:0] err_q, err_d;
  logic [WIDTH-1:0] sr_q [LANES];
  logic [WIDTH-1:0] sr_d [LANES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= '0;
      for (int i = 0; i < LANES; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      for (int i = 0; i < LANES; i++) sr_q[i] <= sr_d[i];
    end
  end

  // Priority is clear > crc_start > bit_en. A crc_start accepted in ACCUM
  // still lets a coincident bit_en accumulate its payload bit first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    for (int i = 0; i < LANES; i++) sr_d[i] = sr_q[i];

    if (bus.clear) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
      err_d   = '0;
      for (int i = 0; i < LANES; i++) sr_d[i] = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.bit_en) begin
            for (int i = 0; i < LANES; i++)
              sr_d[i] = {sr_q[i][WIDTH-2:0], 1'b0} ^
                        (((sr_q[i][WIDTH-1] ^ bus.data_in[i]) != 1'b0) ? POLY : '0);
          end
          if (bus.crc_start) begin
            mode_d  = bus.mode;
            cnt_d   = CW'(WIDTH - 1);
            state_d = ST_CRC;
          end
        end
        ST_CRC: begin
          if (bus.bit_en) begin
            for (int i = 0; i < LANES; i++) begin
              // The received bit is compared against the CRC MSB before that MSB shifts away.
              if (mode_q) err_d[i] = err_q[i] | (bus.data_in[i] ^ sr_q[i][WIDTH-1]);
              sr_d[i] = {sr_q[i][WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end
        default: begin
          // DONE: hold until clear or reset.
        end
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bus.crc[g*WIDTH +: WIDTH] = sr_q[g];
    assign bus.crc_out[g]            = (state_q == ST_CRC) & sr_q[g][WIDTH-1];
  end

  assign bus.crc_phase = (state_q == ST_CRC);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.crc_err   = err_q;
  assign bus.state_dbg = state_q;

endmodule
